// File: rtl/fifo_sync_ram_ctrl.sv
// rtl/fifo_sync_ram_ctrl.sv - single-clock FIFO controller sequencing a dual-port sync-read RAM
//
// Generates RAM write/read addresses and enables, tracks occupancy and drives
// registered FULL/EMPTY/status flags. Write data and read data pass straight through.
//
// Optional feature macro: FIFO_CTRL_THRESH_EN (builds registered almost-full/almost-empty flags;
// when undefined afull and aempty are tied 0 and the threshold parameters are unused).
//
// Ports:
//   clock, reset_n        single rising-edge clock, asynchronous active-low reset
//   we, data              push request and push data
//   re                    pop request
//   q, dvld               pop data (= mem_rdata) and its one-cycle valid
//   full, empty           registered flags: no push / no pop accepted this cycle
//   afull, aempty         registered threshold flags (macro-gated)
//   wrcnt                 occupancy 0..DEPTH
//   overflow, underflow   one-cycle pulses for push while full / pop while empty
//   mem_wdata, mem_waddr, mem_wen   RAM write port
//   mem_raddr, mem_ren, mem_rdata   RAM read port (rdata valid one cycle after mem_ren)

module fifo_sync_ram_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 128,
    parameter int AW        = 7,
    parameter int AFULL_TH  = 120,
    parameter int AEMPTY_TH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             we,
    input  logic [WIDTH-1:0] data,
    input  logic             re,
    output logic [WIDTH-1:0] q,
    output logic             dvld,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic [AW:0]      wrcnt,
    output logic             overflow,
    output logic             underflow,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [AW-1:0]    mem_waddr,
    output logic             mem_wen,
    output logic [AW-1:0]    mem_raddr,
    output logic             mem_ren,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_next;
    logic          full_q;
    logic          empty_q;
    logic          dvld_q;
    logic          ovf_q;
    logic          udf_q;
    logic          push_ok;
    logic          pop_ok;

    // Acceptance is decided purely from the registered flags, so a push and a
    // pop in the same cycle never see each other's effect.
    assign push_ok = we & ~full_q;
    assign pop_ok  = re & ~empty_q;

    always_comb begin
        cnt_next = cnt;
        if (push_ok && !pop_ok) begin
            cnt_next = cnt + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            cnt_next = cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            dvld_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            // Explicit wrap keeps non-power-of-two depths contiguous.
            if (push_ok) begin
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + PTR_ONE;
            end
            if (pop_ok) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + PTR_ONE;
            end
            cnt     <= cnt_next;
            full_q  <= (cnt_next == CNT_DEPTH);
            empty_q <= (cnt_next == '0);
            // The RAM samples mem_ren on the same edge, so its data and dvld line up.
            dvld_q  <= pop_ok;
            ovf_q   <= we & full_q;
            udf_q   <= re & empty_q;
        end
    end

`ifdef FIFO_CTRL_THRESH_EN
    localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_TH);

    logic afull_q;
    logic aempty_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= (cnt_next >= AFULL_LVL);
            aempty_q <= (cnt_next <= AEMPTY_LVL);
        end
    end

    assign afull  = afull_q;
    assign aempty = aempty_q;
`else
    assign afull  = 1'b0;
    assign aempty = 1'b0;
`endif

    assign q         = mem_rdata;
    assign dvld      = dvld_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign wrcnt     = cnt;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign mem_wdata = data;
    assign mem_waddr = wptr;
    assign mem_wen   = push_ok;
    assign mem_raddr = rptr;
    assign mem_ren   = pop_ok;

endmodule
